// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for the EX stage.
//
// Performs DIV (signed) and DIVU (unsigned) by running one shift/subtract
// iteration per clock on the absolute values of the operands. The quotient
// and remainder signs are fixed up at the end. EX holds start_i high and
// stalls the pipeline until ready_o is seen.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU (unsigned)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request; held high until ready_o is seen
//   annul_i       cancels an in-flight division (flush)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
module div #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

  logic [1:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;
  // {partial remainder, dividend/quotient bits, spare}: the dividend is
  // preloaded one bit left so each iteration's trial subtract already sees
  // the next dividend bit in the partial-remainder window.
  logic [2*DATA_W:0]   dividend_r;
  logic [DATA_W-1:0]   divisor_r;
  logic                neg_quo_r;
  logic                neg_rem_r;

  logic [DATA_W-1:0]   op1_abs_s;
  logic [DATA_W-1:0]   op2_abs_s;
  logic [DATA_W:0]     diff_s;
  logic [2*DATA_W:0]   next_dividend_s;
  logic [DATA_W-1:0]   quo_fix_s;
  logic [DATA_W-1:0]   rem_fix_s;

  // Two's-complement magnitude of a value when it is a negative signed number.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic is_signed);
    if (is_signed && v[DATA_W-1]) begin
      return ~v + DATA_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Conditional two's-complement negation used for the final sign fix-up.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic en);
    if (en) begin
      return ~v + DATA_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Operand magnitudes, captured only on the accept edge.
  always_comb begin
    op1_abs_s = abs_val(opdata1_i, signed_div_i);
    op2_abs_s = abs_val(opdata2_i, signed_div_i);
  end

  // One restoring iteration: trial subtract, keep it only if non-negative.
  always_comb begin
    diff_s = {1'b0, dividend_r[2*DATA_W-1:DATA_W]} - {1'b0, divisor_r};
    if (diff_s[DATA_W]) begin
      next_dividend_s = {dividend_r[2*DATA_W-1:0], 1'b0};
    end else begin
      next_dividend_s = {diff_s[DATA_W-1:0], dividend_r[DATA_W-1:0], 1'b1};
    end
  end

  // Sign correction of the finished magnitudes. The remainder sits one bit
  // higher than the quotient because of the preload shift.
  always_comb begin
    quo_fix_s = neg_if(dividend_r[DATA_W-1:0], neg_quo_r);
    rem_fix_s = neg_if(dividend_r[2*DATA_W:DATA_W+1], neg_rem_r);
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FREE;
      cnt_r      <= {CNT_W{1'b0}};
      dividend_r <= {(2*DATA_W+1){1'b0}};
      divisor_r  <= {DATA_W{1'b0}};
      neg_quo_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      result_o   <= {(2*DATA_W){1'b0}};
      ready_o    <= 1'b0;
    end else begin
      case (state_r)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= {(2*DATA_W){1'b0}};
          // A simultaneous annul suppresses the request entirely.
          if (start_i && !annul_i) begin
            if (opdata2_i == {DATA_W{1'b0}}) begin
              state_r <= S_BYZERO;
            end else begin
              dividend_r <= {{DATA_W{1'b0}}, op1_abs_s, 1'b0};
              divisor_r  <= op2_abs_s;
              neg_quo_r  <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem_r  <= signed_div_i && opdata1_i[DATA_W-1];
              cnt_r      <= {CNT_W{1'b0}};
              state_r    <= S_ON;
            end
          end else begin
            state_r <= S_FREE;
          end
        end
        S_BYZERO: begin
          // ready_o is raised by END on the following edge.
          ready_o  <= 1'b0;
          result_o <= {(2*DATA_W){1'b0}};
          state_r  <= S_END;
        end
        S_ON: begin
          if (annul_i) begin
            ready_o  <= 1'b0;
            result_o <= {(2*DATA_W){1'b0}};
            state_r  <= S_FREE;
          end else if (cnt_r != CNT_DONE) begin
            dividend_r <= next_dividend_s;
            cnt_r      <= cnt_r + CNT_W'(1);
          end else begin
            result_o <= {rem_fix_s, quo_fix_s};
            ready_o  <= 1'b1;
            state_r  <= S_END;
          end
        end
        S_END: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= {(2*DATA_W){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            state_r  <= S_FREE;
          end else begin
            ready_o <= 1'b1;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= {(2*DATA_W){1'b0}};
          state_r  <= S_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: self-checking bench for div. Table vectors, hand-written annul and
// reset sequences, and randomized operations checked against an arithmetic
// reference model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        pre_annul;
    logic [63:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, C-style truncation, remainder takes
  // the dividend's sign; divide-by-zero yields zero; -2^31/-1 wraps.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    int sa, sb, q, r;
    logic [31:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv, qv};
  endfunction

  // Issue one division, measure edges from accept to ready, check result,
  // hold stability and the drop of start_i.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic scramble, input logic pre_annul,
                        input logic [63:0] exp_res, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    annul      = pre_annul;
    if (pre_annul) begin
      @(posedge clk);
      @(negedge clk);
      annul = 1'b0;
    end
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) break;
      if (scramble) begin
        opdata1 = $urandom;
        opdata2 = $urandom;
      end
      @(posedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 65'(lat), 65'(exp_lat));
    chk({tag, "_result"}, {1'b0, result}, {1'b0, exp_res});
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_hold"}, {ready, result}, {1'b1, exp_res});
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_drop"}, {ready, result}, 65'd0);
  endtask

  vec_t vecs[$];
  int   seen;
  int   lat;

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {ready, result}, 65'd0);
    rst = 1'b0;

    vecs.push_back('{32'd100,        32'd7,          1'b0, 1'b0, {32'd2, 32'd14},                33});
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33});
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0, {32'd1, 32'h7FFF_FFFC},         33});
    vecs.push_back('{32'd1234,       32'd0,          1'b0, 1'b0, 64'd0,                          2});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, {32'd0, 32'h8000_0000},         33});
    vecs.push_back('{32'hFFFF_FFFF,  32'h10,         1'b0, 1'b0, {32'hF, 32'h0FFF_FFFF},         33});
    vecs.push_back('{32'd50,         32'd5,          1'b0, 1'b1, {32'd0, 32'd10},                33});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, {32'd1, 32'hFFFF_FFFD},         33});
    vecs.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 1'b0, {32'hFFFF_FFFF, 32'd3},         33});
    vecs.push_back('{32'd5,          32'd7,          1'b0, 1'b0, {32'd5, 32'd0},                 33});
    vecs.push_back('{32'hFFFF_FFFF,  32'd0,          1'b1, 1'b1, 64'd0,                          2});

    foreach (vecs[i]) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'(i % 2), vecs[i].pre_annul,
             vecs[i].exp_res, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Annul at cnt=10: no result ever appears, then a fresh request works.
    @(negedge clk);
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) seen = 1;
    end
    chk("annul_no_ready", 65'(seen), 65'd0);
    do_div(32'd50, 32'd5, 1'b0, 1'b0, 1'b0, {32'd0, 32'd10}, 33, "after_annul");

    // Reset at cnt=20 with start still held: outputs clear, then the new
    // operands are accepted one edge later and complete normally.
    @(negedge clk);
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    opdata1 = 32'hFFFF_FFFF;
    opdata2 = 32'h10;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_op", {ready, result}, 65'd0);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ready) break;
    end
    chk("after_reset_latency", 65'(lat), 65'd34);
    chk("after_reset_result", {1'b0, result}, {1'b0, 32'hF, 32'h0FFF_FFFF});
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Randomized operations against the reference model, operands
    // scrambled every cycle after acceptance.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(0, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      s = 1'($urandom_range(0, 1));
      do_div(a, b, s, 1'b1, 1'b0, ref_div(a, b, s), (b == 32'd0) ? 2 : 33,
             $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
